fp_add_subt_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder/subtractor serving the CORDIC coprocessor datapath.
- Consumes operand A/B, operation select and the begin/ack handshake that the CORDIC FSM drives each micro-iteration.
- Returns the result plus a ready flag.
- One operation in flight; fixed latency; result held until acknowledged.

---
 rtl/fp_add_subt_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_fp_add_subt_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_subt_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor for the CORDIC datapath.
// One operation in flight: IDLE -> SWAP -> ALIGN -> ADD -> NORM -> PACK -> DONE.
module fp_add_subt_seq #(
  parameter int unsigned W  = 32,
  parameter int unsigned E  = 8,
  parameter int unsigned SW = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_fsm_add_subt,
  input  logic         ack_fsm_add_subt,
  input  logic         op_add_subt,
  input  logic [W-1:0] add_subt_dataA,
  input  logic [W-1:0] add_subt_dataB,
  output logic         ready_add_subt,
  output logic [W-1:0] result_add_subt,
  output logic         overflow_flag,
  output logic         underflow_flag
);

  localparam int unsigned MW  = SW + 1;       // mantissa with hidden bit
  localparam int unsigned AW  = MW + 3;       // plus three guard bits
  localparam int unsigned LzW = $clog2(AW);

  localparam logic [E-1:0] AlignLimit = E'(AW);
  localparam logic [E:0]   ExpMax     = {1'b0, {E{1'b1}}};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSwap  = 3'd1;
  localparam logic [2:0] StAlign = 3'd2;
  localparam logic [2:0] StAdd   = 3'd3;
  localparam logic [2:0] StNorm  = 3'd4;
  localparam logic [2:0] StPack  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          op_q, op_d;
  logic          sign_big_q, sign_big_d;
  logic          eff_sub_q, eff_sub_d;
  logic          special_q, special_d;
  logic [E-1:0]  exp_big_q, exp_big_d;
  logic [E-1:0]  exp_diff_q, exp_diff_d;
  logic [MW-1:0] man_big_q, man_big_d;
  logic [MW-1:0] man_small_q, man_small_d;
  logic [AW-1:0] small_al_q, small_al_d;
  logic [AW:0]   sum_q, sum_d;
  logic [SW-1:0] norm_man_q, norm_man_d;
  // Two's-complement exponent, wide enough to go negative after a large left shift.
  logic [E+1:0]  norm_exp_q, norm_exp_d;
  logic          zero_q, zero_d;
  logic [W-1:0]  result_q, result_d;
  logic          of_q, of_d;
  logic          uf_q, uf_d;

  logic [E-1:0]  exp_a, exp_b;
  logic [MW-1:0] man_a, man_b;
  logic          sign_a, sign_b;
  logic          a_ge_b;
  logic [AW-1:0] big_al;
  logic [AW-1:0] norm_full;
  logic [LzW-1:0] lzc;
  logic          lz_found;
  logic          exp_neg;
  logic          unused_norm;

  assign exp_a  = a_q[W-2:SW];
  assign exp_b  = b_q[W-2:SW];
  assign man_a  = (exp_a == '0) ? '0 : {1'b1, a_q[SW-1:0]};
  assign man_b  = (exp_b == '0) ? '0 : {1'b1, b_q[SW-1:0]};
  assign sign_a = a_q[W-1];
  assign sign_b = b_q[W-1] ^ op_q;
  assign a_ge_b = {exp_a, man_a} >= {exp_b, man_b};
  assign big_al = {man_big_q, 3'b000};
  assign exp_neg = norm_exp_q[E+1];

  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!lz_found && sum_q[i]) begin
        lzc      = LzW'(AW - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (sum_q[AW]) begin
      norm_full = sum_q[AW:1];
    end else begin
      norm_full = sum_q[AW-1:0] << lzc;
    end
  end

  // Hidden bit and guard bits are dropped when packing (round toward zero).
  assign unused_norm = ^{norm_full[AW-1], norm_full[2:0]};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sign_big_d  = sign_big_q;
    eff_sub_d   = eff_sub_q;
    special_d   = special_q;
    exp_big_d   = exp_big_q;
    exp_diff_d  = exp_diff_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    small_al_d  = small_al_q;
    sum_d       = sum_q;
    norm_man_d  = norm_man_q;
    norm_exp_d  = norm_exp_q;
    zero_d      = zero_q;
    result_d    = result_q;
    of_d        = of_q;
    uf_d        = uf_q;

    case (state_q)
      StIdle: begin
        if (beg_fsm_add_subt) begin
          a_d     = add_subt_dataA;
          b_d     = add_subt_dataB;
          op_d    = op_add_subt;
          state_d = StSwap;
        end
      end
      StSwap: begin
        special_d = (exp_a == '1) || (exp_b == '1);
        eff_sub_d = sign_a ^ sign_b;
        if (a_ge_b) begin
          sign_big_d  = sign_a;
          exp_big_d   = exp_a;
          man_big_d   = man_a;
          man_small_d = man_b;
          exp_diff_d  = exp_a - exp_b;
        end else begin
          sign_big_d  = sign_b;
          exp_big_d   = exp_b;
          man_big_d   = man_b;
          man_small_d = man_a;
          exp_diff_d  = exp_b - exp_a;
        end
        state_d = StAlign;
      end
      StAlign: begin
        if (exp_diff_q >= AlignLimit) begin
          small_al_d = '0;
        end else begin
          small_al_d = {man_small_q, 3'b000} >> exp_diff_q;
        end
        state_d = StAdd;
      end
      StAdd: begin
        if (eff_sub_q) begin
          sum_d = {1'b0, big_al} - {1'b0, small_al_q};
        end else begin
          sum_d = {1'b0, big_al} + {1'b0, small_al_q};
        end
        state_d = StNorm;
      end
      StNorm: begin
        zero_d     = (sum_q == '0);
        norm_man_d = norm_full[AW-2:3];
        if (sum_q[AW]) begin
          norm_exp_d = {2'b00, exp_big_q} + (E+2)'(1);
        end else begin
          norm_exp_d = {2'b00, exp_big_q} - (E+2)'(lzc);
        end
        state_d = StPack;
      end
      StPack: begin
        of_d = 1'b0;
        uf_d = 1'b0;
        if (special_q) begin
          result_d = {1'b0, {E{1'b1}}, 1'b1, {(SW-1){1'b0}}};
        end else if (zero_q) begin
          result_d = '0;
        end else if (!exp_neg && (norm_exp_q[E:0] >= ExpMax)) begin
          result_d = {sign_big_q, {E{1'b1}}, {SW{1'b0}}};
          of_d     = 1'b1;
        end else if (exp_neg || (norm_exp_q == '0)) begin
          result_d = {sign_big_q, {(W-1){1'b0}}};
          uf_d     = 1'b1;
        end else begin
          result_d = {sign_big_q, norm_exp_q[E-1:0], norm_man_q};
        end
        state_d = StDone;
      end
      StDone: begin
        if (ack_fsm_add_subt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      sign_big_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      special_q   <= 1'b0;
      exp_big_q   <= '0;
      exp_diff_q  <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      small_al_q  <= '0;
      sum_q       <= '0;
      norm_man_q  <= '0;
      norm_exp_q  <= '0;
      zero_q      <= 1'b0;
      result_q    <= '0;
      of_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sign_big_q  <= sign_big_d;
      eff_sub_q   <= eff_sub_d;
      special_q   <= special_d;
      exp_big_q   <= exp_big_d;
      exp_diff_q  <= exp_diff_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      small_al_q  <= small_al_d;
      sum_q       <= sum_d;
      norm_man_q  <= norm_man_d;
      norm_exp_q  <= norm_exp_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      of_q        <= of_d;
      uf_q        <= uf_d;
    end
  end

  assign ready_add_subt  = (state_q == StDone);
  assign result_add_subt = result_q;
  assign overflow_flag   = of_q;
  assign underflow_flag  = uf_q;

endmodule

// File: tb/tb_fp_add_subt_seq.sv
// Scoreboard bench for fp_add_subt_seq: driver queues expected results, monitor checks on ready.
module tb_fp_add_subt_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        beg = 1'b0;
  logic        ack = 1'b0;
  logic        op  = 1'b0;
  logic [31:0] da  = '0;
  logic [31:0] db  = '0;
  logic        ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  fp_add_subt_seq #(.W(32), .E(8), .SW(23)) dut (
    .clk              (clk),
    .rst              (rst),
    .beg_fsm_add_subt (beg),
    .ack_fsm_add_subt (ack),
    .op_add_subt      (op),
    .add_subt_dataA   (da),
    .add_subt_dataB   (db),
    .ready_add_subt   (ready),
    .result_add_subt  (result),
    .overflow_flag    (ovf),
    .underflow_flag   (unf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        of;
    logic        uf;
    int          start;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: real-valued significands scaled by 8 (three guard bits), truncated.
  function automatic logic [33:0] ref_fp(input logic [31:0] a, input logic [31:0] b,
                                         input logic o);
    int ea, eb, eg, es, d, e;
    longint ma, mb, mg, ms, sbig, ssml, s;
    logic sa, sb, sg, ssm;
    logic [7:0] e8;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ o;
    if (ea == 255 || eb == 255) return {2'b00, 32'h7FC0_0000};
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (longint'(1) << 23));
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (longint'(1) << 23));
    if (ea > eb || (ea == eb && ma >= mb)) begin
      eg = ea; mg = ma; sg = sa; es = eb; ms = mb; ssm = sb;
    end else begin
      eg = eb; mg = mb; sg = sb; es = ea; ms = ma; ssm = sa;
    end
    d = eg - es;
    sbig = mg * 8;
    ssml = (d >= 27) ? 0 : ((ms * 8) >> d);
    s = (sg == ssm) ? sbig + ssml : sbig - ssml;
    if (s == 0) return 34'h0;
    e = eg;
    while (s >= (longint'(1) << 27)) begin s = s >> 1; e++; end
    while (s < (longint'(1) << 26)) begin s = s << 1; e--; end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, sg, 31'h0};
    e8 = 8'(e);
    return {2'b00, sg, e8, s[25:3]};
  endfunction

  // Monitor: pops on the rising edge of ready, then checks the result holds while ready.
  initial begin
    bit   prev;
    exp_t cur;
    prev = 1'b0;
    cur  = '{res: '0, of: 1'b0, uf: 1'b0, start: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ready && !prev) begin
          if (sbq.size() == 0) begin
            check("unexpected_ready", 32'(ready), 32'h0);
          end else begin
            cur = sbq.pop_front();
            check("result", result, cur.res);
            check("overflow", 32'(ovf), 32'(cur.of));
            check("underflow", 32'(unf), 32'(cur.uf));
            check("latency", 32'(cyc - cur.start), 32'd5);
          end
        end else if (ready) begin
          check("hold_result", result, cur.res);
        end
      end
      prev = ready;
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [33:0] expv, input int hold, input bit beg_in_align,
                        input bit beg_with_ack);
    int n;
    exp_t x;
    @(posedge clk); #1;
    da = a; db = b; op = o; beg = 1'b1;
    x.res = expv[31:0]; x.of = expv[33]; x.uf = expv[32]; x.start = cyc + 1;
    sbq.push_back(x);
    @(posedge clk); #1;
    beg = 1'b0; da = $urandom; db = $urandom; op = 1'($urandom_range(0, 1));
    if (beg_in_align) begin
      @(posedge clk); #1;
      beg = 1'b1; da = $urandom; db = $urandom;
      @(posedge clk); #1;
      beg = 1'b0;
    end
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'h1);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ack = 1'b1;
    if (beg_with_ack) begin
      beg = 1'b1; da = $urandom; db = $urandom;
    end
    @(posedge clk); #1;
    ack = 1'b0; beg = 1'b0;
    check("ready_drop", 32'(ready), 32'h0);
  endtask

  task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
    logic [7:0] ea, eb;
    a  = $urandom;
    b  = $urandom;
    ea = 8'($urandom_range(0, 254));
    if ($urandom_range(0, 15) == 0) ea = 8'hFF;
    if ($urandom_range(0, 1) == 1) begin
      eb = ea + 8'($urandom_range(0, 3));
      if (eb < ea) eb = 8'hFE;
    end else begin
      eb = 8'($urandom_range(0, 254));
    end
    if ($urandom_range(0, 7) == 0) eb = ea;
    a[30:23] = ea;
    b[30:23] = eb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        ro;
    #12;
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_flags", {30'h0, ovf, unf}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, {2'b00, 32'h4000_0000}, 20, 1'b0, 1'b0);
    run_op(32'h3FC0_0000, 32'hC020_0000, 1'b1, {2'b00, 32'h4080_0000}, 0, 1'b1, 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b1, {2'b00, 32'hC000_0000}, 1, 1'b0, 1'b1);
    run_op(32'h3F1B_74EE, 32'h3F1B_74EE, 1'b1, {2'b00, 32'h0000_0000}, 0, 1'b0, 0);
    run_op(32'h3F1B_74EE, 32'h0000_0000, 1'b0, {2'b00, 32'h3F1B_74EE}, 2, 1'b0, 1'b1);
    run_op(32'h3F80_0000, 32'h3080_0000, 1'b0, {2'b00, 32'h3F80_0000}, 0, 1'b0, 1'b0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 1'b0, {2'b00, 32'h7FC0_0000}, 0, 1'b0, 1'b0);
    run_op(32'h0080_0001, 32'h0080_0000, 1'b1, {2'b01, 32'h0000_0000}, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rnd_pair(ra, rb);
      ro = 1'($urandom_range(0, 1));
      run_op(ra, rb, ro, ref_fp(ra, rb, ro), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {2'b10, 32'h7F80_0000}, 0, 1'b0, 1'b0);

    // Abort an operation while it is in ADD; outputs must clear with no clock edge.
    @(posedge clk); #1;
    da = 32'h4000_0000; db = 32'h3F80_0000; op = 1'b0; beg = 1'b1;
    @(posedge clk); #1;
    beg = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_rst_ready", 32'(ready), 32'h0);
    check("async_rst_result", result, 32'h0);
    check("async_rst_flags", {30'h0, ovf, unf}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("post_rst_idle", 32'(ready), 32'h0);
    run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, {2'b00, 32'h4040_0000}, 0, 1'b0, 1'b0);

    repeat (10) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
